// File: rtl/cbd_noise_sampler.sv
// Centered-binomial noise sampler: packs 32-bit uniform words into a 64-bit bit buffer and
// emits popcount(a)-popcount(b) samples on AXI-Stream. `CBD_NOISE_STATS_EN adds stat outputs.
module cbd_noise_sampler #(
    parameter int unsigned ETA   = 8,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
`ifdef CBD_NOISE_STATS_EN
    output logic [31:0]      stat_words,
    output logic signed [31:0] stat_sum,
`endif
    output logic             done
);

    localparam int unsigned W2   = 2 * ETA;
    localparam logic [6:0]  W2_F = 7'(W2);
    localparam int unsigned NW   = CNT_W + 6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [63:0]      buf_q, buf_d;
    logic [6:0]       fill_q, fill_d;
    logic [CNT_W-1:0] rem_ext_q, rem_ext_d;
    logic [CNT_W-1:0] rem_out_q, rem_out_d;
    logic [31:0]      mdata_q, mdata_d;
    logic             mvalid_q, mvalid_d;
    logic             mlast_q, mlast_d;
    logic             done_q, done_d;

    logic             accept, extract, out_hs;
    logic [5:0]       pop_a, pop_b;
    logic [31:0]      sample_raw;
    logic [NW-1:0]    need_bits;
    logic [63:0]      shifted;
    logic [6:0]       wr_pos;

    // Only pull words while the buffer has room and the run still needs bits.
    assign need_bits     = NW'(rem_ext_q) * NW'(W2);
    assign s_axis_tready = (state_q == RUN) && (fill_q <= 7'd32) && (NW'(fill_q) < need_bits);
    assign accept        = s_axis_tready && s_axis_tvalid;
    assign out_hs        = mvalid_q && m_axis_tready;
    assign extract       = (state_q == RUN) && (rem_ext_q != '0) && (fill_q >= W2_F)
                           && (!mvalid_q || m_axis_tready);

    assign m_axis_tdata  = mdata_q;
    assign m_axis_tvalid = mvalid_q;
    assign m_axis_tlast  = mlast_q;
    assign busy          = (state_q == RUN);
    assign done          = done_q;

    always_comb begin
        pop_a = '0;
        pop_b = '0;
        for (int unsigned i = 0; i < ETA; i++) begin
            pop_a = pop_a + 6'(buf_q[i]);
            pop_b = pop_b + 6'(buf_q[ETA + i]);
        end
        sample_raw = 32'(pop_a) - 32'(pop_b);
    end

    always_comb begin
        state_d   = state_q;
        rem_ext_d = rem_ext_q;
        rem_out_d = rem_out_q;
        mdata_d   = mdata_q;
        mvalid_d  = mvalid_q;
        mlast_d   = mlast_q;
        done_d    = 1'b0;

        // New word lands just above the bits that survive this cycle's extraction.
        shifted = extract ? (buf_q >> W2) : buf_q;
        wr_pos  = extract ? (fill_q - W2_F) : fill_q;
        buf_d   = accept ? (shifted | ({32'b0, s_axis_tdata} << wr_pos)) : shifted;
        fill_d  = fill_q + (accept ? 7'd32 : 7'd0) - (extract ? W2_F : 7'd0);

        if (extract) begin
            rem_ext_d = rem_ext_q - CNT_W'(1);
            mdata_d   = sample_raw << SHIFT;
            mvalid_d  = 1'b1;
            mlast_d   = (rem_ext_q == CNT_W'(1));
        end else if (out_hs) begin
            mvalid_d = 1'b0;
            mlast_d  = 1'b0;
        end
        if (out_hs) rem_out_d = rem_out_q - CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_samples == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_ext_d = num_samples;
                        rem_out_d = num_samples;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (out_hs && (rem_out_q == CNT_W'(1))) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    fill_d    = '0;
                    buf_d     = '0;
                    mvalid_d  = 1'b0;
                    mlast_d   = 1'b0;
                    rem_ext_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            fill_q    <= '0;
            rem_ext_q <= '0;
            rem_out_q <= '0;
            mdata_q   <= '0;
            mvalid_q  <= 1'b0;
            mlast_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            rem_ext_q <= rem_ext_d;
            rem_out_q <= rem_out_d;
            mdata_q   <= mdata_d;
            mvalid_q  <= mvalid_d;
            mlast_q   <= mlast_d;
            done_q    <= done_d;
        end
    end

`ifdef CBD_NOISE_STATS_EN
    logic [31:0] words_q, words_d;
    logic [31:0] sum_q, sum_d;

    always_comb begin
        words_d = words_q;
        sum_d   = sum_q;
        if ((state_q == IDLE) && start) begin
            words_d = '0;
            sum_d   = '0;
        end else begin
            if (accept)  words_d = words_q + 32'd1;
            if (extract) sum_d   = sum_q + sample_raw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
            sum_q   <= '0;
        end else begin
            words_q <= words_d;
            sum_q   <= sum_d;
        end
    end

    assign stat_words = words_q;
    assign stat_sum   = sum_q;
`endif

endmodule
